// File: rtl/r2mdc_pkg.sv
// Shared types for the radix-2 MDC FFT pipeline: sample width, complex sample,
// and the merger's phase encoding.
package r2mdc_pkg;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_STREAM = 1'b0,
        ST_DRAIN  = 1'b1
    } merge_state_t;

endpackage

// File: rtl/mdc_output_merger_if.sv
// Dual-lane input / serial output bus of the MDC output merger.
interface mdc_output_merger_if;
    import r2mdc_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_0_re;
    logic signed [DATA_W-1:0] in_0_im;
    logic signed [DATA_W-1:0] in_1_re;
    logic signed [DATA_W-1:0] in_1_im;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic                     out_first;
    logic                     out_last;

    modport master (
        output in_valid, in_0_re, in_0_im, in_1_re, in_1_im,
        input  in_ready, out_valid, out_re, out_im, out_first, out_last
    );

    modport slave (
        input  in_valid, in_0_re, in_0_im, in_1_re, in_1_im,
        output in_ready, out_valid, out_re, out_im, out_first, out_last
    );

endinterface

// File: rtl/mdc_sample_buffer.sv
// Lane-1 holding store: one write port, one registered read port, no reset.
module mdc_sample_buffer
    import r2mdc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  cplx_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output cplx_t         rd_data
);

    cplx_t mem [DEPTH];
    cplx_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mdc_output_merger.sv
// Serialises an MDC FFT's two output lanes into one stream: lane-0 samples pass
// through with one cycle of latency, lane-1 samples are buffered and drained after.
module mdc_output_merger
    import r2mdc_pkg::*;
#(
    parameter int POINTS = 16
) (
    input logic                clk,
    input logic                rst_n,
    mdc_output_merger_if.slave bus
);

    localparam int HALF = POINTS / 2;
    localparam int AW   = $clog2(HALF);
    localparam logic [AW-1:0] LAST_IDX = AW'(HALF - 1);

    merge_state_t             state_q, state_d;
    logic [AW-1:0]            pair_cnt_q, pair_cnt_d;
    logic [AW-1:0]            drain_cnt_q, drain_cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_first_q, out_first_d;
    logic                     out_last_q, out_last_d;
    logic signed [DATA_W-1:0] out_re_q, out_re_d;
    logic signed [DATA_W-1:0] out_im_q, out_im_d;

    logic          accept;
    logic [AW-1:0] rd_addr;
    cplx_t         wr_data;
    cplx_t         rd_data;

    assign accept = bus.in_valid && in_ready_q;

    // The read port is registered, so the address runs one entry ahead of the
    // sample being presented; parking it at 0 while streaming has buffer[0]
    // ready on the first drain cycle.
    assign rd_addr = (state_q == ST_DRAIN) ? drain_cnt_q + AW'(1) : '0;

    always_comb begin
        wr_data.re = bus.in_1_re;
        wr_data.im = bus.in_1_im;
    end

    mdc_sample_buffer #(
        .DEPTH (HALF),
        .AW    (AW)
    ) u_lane1_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (pair_cnt_q),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        pair_cnt_d  = pair_cnt_q;
        drain_cnt_d = drain_cnt_q;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;

        case (state_q)
            ST_STREAM: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_first_d = (pair_cnt_q == '0);
                    out_re_d    = bus.in_0_re;
                    out_im_d    = bus.in_0_im;
                    if (pair_cnt_q == LAST_IDX) begin
                        pair_cnt_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        pair_cnt_d = pair_cnt_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                out_valid_d = 1'b1;
                out_last_d  = (drain_cnt_q == LAST_IDX);
                out_re_d    = rd_data.re;
                out_im_d    = rd_data.im;
                if (drain_cnt_q == LAST_IDX) begin
                    drain_cnt_d = '0;
                    state_d     = ST_STREAM;
                end else begin
                    drain_cnt_d = drain_cnt_q + AW'(1);
                end
            end
            default: state_d = ST_STREAM;
        endcase

        in_ready_d = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STREAM;
            pair_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            pair_cnt_q  <= pair_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;

endmodule

// File: tb/tb_mdc_output_merger.sv
// Directed bench for mdc_output_merger at POINTS=8: ordering, gaps, back-to-back
// frames, drain-time input rejection, mid-frame reset and extreme values.
module tb_mdc_output_merger;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests_run;
    int   tests_failed;

    logic signed [15:0] mon_re[$];
    logic signed [15:0] mon_im[$];
    bit                 mon_first[$];
    bit                 mon_last[$];
    int                 mon_cyc[$];
    int                 acc_cyc[$];

    mdc_output_merger_if bus ();

    mdc_output_merger #(.POINTS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record accepts and output samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_cyc.push_back(cyc);
        if (bus.out_valid === 1'b1) begin
            mon_re.push_back(bus.out_re);
            mon_im.push_back(bus.out_im);
            mon_first.push_back(bus.out_first);
            mon_last.push_back(bus.out_last);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic clear_mon();
        mon_re.delete();
        mon_im.delete();
        mon_first.delete();
        mon_last.delete();
        mon_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a pair on the bus until it is accepted; returns at posedge + 1.
    task automatic send_pair(input int a_re, input int a_im, input int b_re, input int b_im);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_0_re  = 16'(a_re);
        bus.in_0_im  = 16'(a_im);
        bus.in_1_re  = 16'(b_re);
        bus.in_1_im  = 16'(b_im);
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_pair_timeout: in_ready never high, required 1");
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_0_re  = '0;
        bus.in_0_im  = '0;
        bus.in_1_re  = '0;
        bus.in_1_im  = '0;
        idle(3);
        tests_run++;
        if ({bus.in_ready, bus.out_valid, bus.out_first, bus.out_last} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 0000",
                     {bus.in_ready, bus.out_valid, bus.out_first, bus.out_last});
        end
        tests_run++;
        if ({bus.out_re, bus.out_im} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h required 00000000", {bus.out_re, bus.out_im});
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: got %b required 0", bus.in_ready);
        end
        idle(1);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_edge: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [33:0] got, ex;
        clear_mon();
        for (int k = 0; k < 4; k++) send_pair(k + 1, -(k + 1), k + 5, -(k + 5));
        bus.in_valid = 1'b0;
        idle(10);
        tests_run++;
        if (mon_re.size() != 8 || acc_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d outputs %0d accepts, required 8 4",
                     mon_re.size(), acc_cyc.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                got = {mon_re[j], mon_im[j], mon_first[j], mon_last[j]};
                ex  = {16'(j + 1), 16'(-(j + 1)), (j == 0), (j == 7)};
                tests_run++;
                if (got !== ex) begin
                    tests_failed++;
                    $display("FAIL basic_sample%0d: got %h required %h", j, got, ex);
                end
                tests_run++;
                if (mon_cyc[j] != acc_cyc[0] + 1 + j) begin
                    tests_failed++;
                    $display("FAIL basic_cycle%0d: got %0d required %0d", j, mon_cyc[j], acc_cyc[0] + 1 + j);
                end
            end
        end
    endtask

    task automatic test_gap();
        logic [33:0] got, ex;
        int          ec;
        clear_mon();
        send_pair(1, -1, 5, -5);
        send_pair(2, -2, 6, -6);
        bus.in_valid = 1'b0;
        idle(2);
        send_pair(3, -3, 7, -7);
        send_pair(4, -4, 8, -8);
        bus.in_valid = 1'b0;
        idle(10);
        tests_run++;
        if (mon_re.size() != 8 || acc_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL gap_count: got %0d outputs %0d accepts, required 8 4",
                     mon_re.size(), acc_cyc.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                got = {mon_re[j], mon_im[j], mon_first[j], mon_last[j]};
                ex  = {16'(j + 1), 16'(-(j + 1)), (j == 0), (j == 7)};
                ec  = acc_cyc[0] + 1 + j + ((j >= 2) ? 2 : 0);
                tests_run++;
                if (got !== ex || mon_cyc[j] != ec) begin
                    tests_failed++;
                    $display("FAIL gap_sample%0d: got %h @%0d required %h @%0d", j, got, mon_cyc[j], ex, ec);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] got, ex;
        bit          rdy, exp_rdy;
        int          acc, n, r, lane;
        clear_mon();
        acc = 0;
        for (int t = 0; t < 12; t++) begin
            bus.in_valid = 1'b1;
            bus.in_0_re  = 16'(10 * acc + 1);
            bus.in_0_im  = 16'(-(10 * acc + 1));
            bus.in_1_re  = 16'(10 * acc + 2);
            bus.in_1_im  = 16'(-(10 * acc + 2));
            @(negedge clk);
            rdy     = bus.in_ready;
            exp_rdy = (t < 4) || (t >= 8);
            tests_run++;
            if (rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL b2b_ready_t%0d: got %b required %b", t, rdy, exp_rdy);
            end
            if (rdy) acc++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        idle(20);
        tests_run++;
        if (acc_cyc.size() != 8 || mon_re.size() != 16) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d accepts %0d outputs, required 8 16",
                     acc_cyc.size(), mon_re.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                r    = j % 8;
                lane = r / 4;
                n    = 4 * (j / 8) + (r % 4);
                got  = {mon_re[j], mon_im[j], mon_first[j], mon_last[j]};
                ex   = {16'(10 * n + 1 + lane), 16'(-(10 * n + 1 + lane)), (r == 0), (r == 7)};
                tests_run++;
                if (got !== ex || mon_cyc[j] != acc_cyc[0] + 1 + j) begin
                    tests_failed++;
                    $display("FAIL b2b_sample%0d: got %h @%0d required %h @%0d",
                             j, got, mon_cyc[j], ex, acc_cyc[0] + 1 + j);
                end
            end
        end
    endtask

    task automatic test_drain_ignore();
        logic [33:0] got, ex;
        int          v;
        clear_mon();
        for (int k = 0; k < 4; k++) send_pair(20 + k, -(20 + k), 30 + k, -(30 + k));
        for (int t = 0; t < 4; t++) begin
            bus.in_valid = 1'b1;
            bus.in_0_re  = 16'h1234;
            bus.in_0_im  = 16'h5A5A;
            bus.in_1_re  = 16'hDEAD;
            bus.in_1_im  = 16'hBEEF;
            @(negedge clk);
            tests_run++;
            if (bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_ready_t%0d: got %b required 0", t, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        idle(6);
        tests_run++;
        if (acc_cyc.size() != 4 || mon_re.size() != 8) begin
            tests_failed++;
            $display("FAIL drain_count: got %0d accepts %0d outputs, required 4 8",
                     acc_cyc.size(), mon_re.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                v   = (j < 4) ? 20 + j : 30 + j - 4;
                got = {mon_re[j], mon_im[j], mon_first[j], mon_last[j]};
                ex  = {16'(v), 16'(-v), (j == 0), (j == 7)};
                tests_run++;
                if (got !== ex) begin
                    tests_failed++;
                    $display("FAIL drain_sample%0d: got %h required %h", j, got, ex);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [33:0] got, ex;
        int          v;
        clear_mon();
        send_pair(40, -40, 44, -44);
        send_pair(41, -41, 45, -45);
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_valid: got %b required 1", bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.in_ready, bus.out_valid, bus.out_first, bus.out_last, bus.out_re, bus.out_im} !== 36'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h required 0",
                     {bus.in_ready, bus.out_valid, bus.out_first, bus.out_last, bus.out_re, bus.out_im});
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_mon();
        for (int k = 0; k < 4; k++) send_pair(50 + k, -(50 + k), 60 + k, -(60 + k));
        bus.in_valid = 1'b0;
        idle(10);
        tests_run++;
        if (mon_re.size() != 8) begin
            tests_failed++;
            $display("FAIL reset_frame_count: got %0d required 8", mon_re.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                v   = (j < 4) ? 50 + j : 60 + j - 4;
                got = {mon_re[j], mon_im[j], mon_first[j], mon_last[j]};
                ex  = {16'(v), 16'(-v), (j == 0), (j == 7)};
                tests_run++;
                if (got !== ex) begin
                    tests_failed++;
                    $display("FAIL reset_frame_sample%0d: got %h required %h", j, got, ex);
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] got, ex;
        int          a_re[4] = '{-32768, 32767, -32768, 32767};
        int          a_im[4] = '{32767, -32768, -32768, 32767};
        clear_mon();
        for (int k = 0; k < 4; k++) send_pair(a_re[k], a_im[k], a_re[3 - k], a_im[3 - k]);
        bus.in_valid = 1'b0;
        idle(10);
        tests_run++;
        if (mon_re.size() != 8) begin
            tests_failed++;
            $display("FAIL ext_count: got %0d required 8", mon_re.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                got = {mon_re[j], mon_im[j]};
                ex  = (j < 4) ? {16'(a_re[j]), 16'(a_im[j])} : {16'(a_re[7 - j]), 16'(a_im[7 - j])};
                tests_run++;
                if (got !== ex) begin
                    tests_failed++;
                    $display("FAIL ext_sample%0d: got %h required %h", j, got, ex);
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        test_reset();
        test_basic();
        test_gap();
        test_back_to_back();
        test_drain_ignore();
        test_mid_reset();
        test_extremes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
